// File: rtl/axi_eth_pkg.sv
// Shared definitions for the Ethernet transmit frame FIFO: write-state
// encodings, default geometry and the drop counter width.
package axi_eth_pkg;

  typedef enum logic {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_e;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_DEPTH_LOG2  = 9;
  localparam int DROP_CNT_W      = 16;

endpackage

// File: rtl/axi_ethernet_tx_fifo_ram.sv
// Simple dual-port frame storage: one write port, one registered read port.
// The read register holds its value while re_i is low.
module axi_ethernet_tx_fifo_ram #(
  parameter int DATA_W = 37,
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ethernet_tx_fifo.sv
// Store-and-forward transmit frame FIFO between the host stream and the
// Ethernet bridge. Frames become readable only once their last beat is stored.
module axi_ethernet_tx_fifo
  import axi_eth_pkg::*;
#(
  parameter int C_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int C_DEPTH_LOG2  = DEF_DEPTH_LOG2
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [C_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [C_DEPTH_LOG2:0]        frame_count,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int KEEP_W = C_TDATA_WIDTH / 8;
  localparam int MEM_W  = C_TDATA_WIDTH + KEEP_W + 1;
  localparam int PTR_W  = C_DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0]      PTR_ONE     = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]      DEPTH_WORDS = {1'b1, {C_DEPTH_LOG2{1'b0}}};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX    = '1;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE    = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

  wr_state_e              wr_state_q, wr_state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       frame_cnt_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;
  logic                   rdy_q;

  logic                   s_hs, full, ram_we, commit_evt, drop_inc;
  logic                   ram_re, rv_free, rv_move, pf_free, pf_move, out_last_hs;
  logic [MEM_W-1:0]       ram_rdata;
  logic                   rv_vld_q, pf_vld_q, out_vld_q;
  logic [MEM_W-1:0]       pf_data_q, out_data_q;

  assign s_hs = s_axis_tvalid & rdy_q;
  assign full = (wr_ptr_q - rd_ptr_q) == DEPTH_WORDS;

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ram_we       = 1'b0;
    commit_evt   = 1'b0;
    drop_inc     = 1'b0;
    if (s_hs) begin
      case (wr_state_q)
        WR_ACCEPT: begin
          if (full) begin
            // Frame cannot fit: forget its stored beats and swallow the rest.
            wr_ptr_d = commit_ptr_q;
            if (s_axis_tlast) drop_inc = 1'b1;
            else              wr_state_d = WR_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast) begin
              commit_ptr_d = wr_ptr_q + PTR_ONE;
              commit_evt   = 1'b1;
            end
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            drop_inc   = 1'b1;
            wr_state_d = WR_ACCEPT;
          end
        end
        default: wr_state_d = WR_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q   <= WR_ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      drop_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      rdy_q        <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rdy_q        <= 1'b1;
      if (drop_inc && drop_cnt_q != DROP_MAX) drop_cnt_q <= drop_cnt_q + DROP_ONE;
      case ({commit_evt, out_last_hs})
        2'b10:   frame_cnt_q <= frame_cnt_q + PTR_ONE;
        2'b01:   frame_cnt_q <= frame_cnt_q - PTR_ONE;
        default: frame_cnt_q <= frame_cnt_q;
      endcase
    end
  end

  axi_ethernet_tx_fifo_ram #(
    .DATA_W (MEM_W),
    .ADDR_W (C_DEPTH_LOG2)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[C_DEPTH_LOG2-1:0]),
    .wdata_i ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[C_DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  // Read pipeline: RAM output register -> prefetch -> output register,
  // each stage advancing when the next one is empty or emptying.
  assign pf_move     = pf_vld_q & (~out_vld_q | m_axis_tready);
  assign pf_free     = ~pf_vld_q | pf_move;
  assign rv_move     = rv_vld_q & pf_free;
  assign rv_free     = ~rv_vld_q | rv_move;
  assign ram_re      = (rd_ptr_q != commit_ptr_q) & rv_free;
  assign out_last_hs = out_vld_q & m_axis_tready & out_data_q[0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q   <= '0;
      rv_vld_q   <= 1'b0;
      pf_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (ram_re) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (ram_re)       rv_vld_q <= 1'b1;
      else if (rv_move) rv_vld_q <= 1'b0;
      if (rv_move)      pf_vld_q <= 1'b1;
      else if (pf_move) pf_vld_q <= 1'b0;
      if (pf_move) begin
        out_vld_q  <= 1'b1;
        out_data_q <= pf_data_q;
      end else if (m_axis_tready) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rv_move) pf_data_q <= ram_rdata;
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q[MEM_W-1 -: C_TDATA_WIDTH];
  assign m_axis_tkeep  = out_data_q[KEEP_W:1];
  assign m_axis_tlast  = out_data_q[0];
  assign frame_count   = frame_cnt_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_axi_ethernet_tx_fifo.sv
// Directed scenarios for the transmit frame FIFO with a beat scoreboard on the
// output stream.
module tb_axi_ethernet_tx_fifo;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [9:0]  frame_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [36:0] sb_q[$];
  int          pop_cyc[$];
  bit          beat_seen = 0;
  bit          stall_prev = 0;
  logic [36:0] stall_val = '0;

  axi_ethernet_tx_fifo #(
    .C_TDATA_WIDTH (32),
    .C_DEPTH_LOG2  (9)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // Output monitor: scoreboard compare on each handshake, hold check on stalls.
  always @(negedge aclk) begin
    logic [36:0] got;
    logic [36:0] exp;
    got = {m_tdata, m_tkeep, m_tlast};
    if (!aresetn) begin
      stall_prev = 0;
    end else begin
      if (m_tvalid) beat_seen = 1;
      if (stall_prev) begin
        checks++;
        if (m_tvalid !== 1'b1 || got !== stall_val) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                   m_tvalid, got, stall_val);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got beat=%h, required no beat", got);
        end else begin
          exp = sb_q.pop_front();
          pop_cyc.push_back(cyc);
          if (got !== exp) begin
            errors++;
            $display("FAIL beat_data: got %h, required %h", got, exp);
          end
        end
      end
      stall_prev = m_tvalid && !m_tready;
      stall_val  = got;
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                            input bit expect_out);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    if (expect_out) sb_q.push_back({d, k, l});
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((sb_q.size() != 0 || m_tvalid) && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending beats valid=%0b, required 0 and valid=0",
               name, sb_q.size(), m_tvalid);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, frame_count, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b v=%0b l=%0b k=%h d=%h fc=%0d dc=%0d, required all 0",
               s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, frame_count, drop_count);
    end
    aresetn = 1'b1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL tready_before_edge: got %0b, required 0", s_tready);
    end
    @(posedge aclk); #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL tready_first_edge: got %0b, required 1", s_tready);
    end
  endtask

  task automatic test_single();
    m_tready = 1'b1;
    drive_beat(32'hDEADBEEF, 4'hF, 1'b1, 1);
    checks++;
    if (frame_count !== 10'd1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_commit: got fc=%0d v=%0b, required fc=1 v=0", frame_count, m_tvalid);
    end
    for (int i = 1; i <= 3; i++) begin
      @(posedge aclk); #1;
      checks++;
      if (m_tvalid !== (i == 3)) begin
        errors++;
        $display("FAIL single_latency: cycle %0d got valid=%0b, required %0b", i, m_tvalid, i == 3);
      end
    end
    @(posedge aclk); #1;
    checks++;
    if (frame_count !== 10'd0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got fc=%0d v=%0b, required fc=0 v=0", frame_count, m_tvalid);
    end
    wait_drain(20, "single");
  endtask

  task automatic test_back_to_back();
    int lasts = 0;
    m_tready = 1'b1;
    pop_cyc.delete();
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 4; b++)
        drive_beat(32'hA000_0000 | (f << 8) | b, (b == 3) ? 4'(4'h1 << f) : 4'hF, b == 3, 1);
    wait_drain(60, "b2b");
    checks++;
    if (pop_cyc.size() !== 12) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats, required 12", pop_cyc.size());
    end else begin
      for (int i = 1; i < 12; i++)
        if (pop_cyc[i] - pop_cyc[i-1] != 1) lasts++;
      checks++;
      if (lasts != 0) begin
        errors++;
        $display("FAIL b2b_gaps: got %0d bubbles, required 0", lasts);
      end
    end
  endtask

  task automatic test_full_frame();
    m_tready = 1'b1;
    for (int i = 0; i < 512; i++)
      drive_beat(32'h5500_0000 + i, 4'hF, i == 511, 1);
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL full_frame_drop: got dc=%0d, required 0", drop_count);
    end
    wait_drain(600, "full_frame");
  endtask

  task automatic test_oversize_drop();
    bit rdy_low = 0;
    m_tready = 1'b1;
    beat_seen = 0;
    for (int i = 0; i < 513; i++) begin
      if (s_tready !== 1'b1) rdy_low = 1;
      drive_beat(32'h6600_0000 + i, 4'hF, i == 512, 0);
    end
    repeat (6) @(posedge aclk);
    #1;
    checks++;
    if (rdy_low !== 1'b0) begin
      errors++;
      $display("FAIL drop_tready: got tready low during frame, required always 1");
    end
    checks++;
    if (drop_count !== 16'd1 || frame_count !== 10'd0) begin
      errors++;
      $display("FAIL drop_counts: got dc=%0d fc=%0d, required dc=1 fc=0", drop_count, frame_count);
    end
    checks++;
    if (beat_seen !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_output: got tvalid seen, required none");
    end
    drive_beat(32'h7777_0001, 4'hF, 1'b0, 1);
    drive_beat(32'h7777_0002, 4'h3, 1'b1, 1);
    wait_drain(20, "after_drop");
  endtask

  task automatic test_stall_toggle();
    int n = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++)
      drive_beat(32'hC0DE_0000 + (i * 32'h111), 4'(i), i == 15, 1);
    while (sb_q.size() != 0 && n < 200) begin
      m_tready = ~m_tready;
      @(posedge aclk); #1;
      n++;
    end
    m_tready = 1'b1;
    wait_drain(20, "stall");
    checks++;
    if (frame_count !== 10'd0) begin
      errors++;
      $display("FAIL stall_fc: got fc=%0d, required 0", frame_count);
    end
  endtask

  task automatic test_commit_collide();
    m_tready = 1'b1;
    drive_beat(32'h1111_AAAA, 4'hF, 1'b1, 1);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    drive_beat(32'h2222_0000, 4'hF, 1'b0, 1);
    checks++;
    if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || frame_count !== 10'd1) begin
      errors++;
      $display("FAIL collide_setup: got v=%0b l=%0b fc=%0d, required v=1 l=1 fc=1",
               m_tvalid, m_tlast, frame_count);
    end
    drive_beat(32'h2222_0001, 4'h7, 1'b1, 1);
    checks++;
    if (frame_count !== 10'd1) begin
      errors++;
      $display("FAIL collide_fc: got fc=%0d, required 1", frame_count);
    end
    wait_drain(20, "collide");
    checks++;
    if (frame_count !== 10'd0) begin
      errors++;
      $display("FAIL collide_final_fc: got fc=%0d, required 0", frame_count);
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++)
      drive_beat(32'hBEEF_0000 + i, 4'hF, i == 9, 1);
    while (!m_tvalid && n < 10) begin
      @(posedge aclk); #1;
      n++;
    end
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata, frame_count, drop_count, s_tready} !== '0) begin
      errors++;
      $display("FAIL midreset_state: got v=%0b l=%0b k=%h d=%h fc=%0d dc=%0d rdy=%0b, required all 0",
               m_tvalid, m_tlast, m_tkeep, m_tdata, frame_count, drop_count, s_tready);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    beat_seen = 0;
    repeat (20) @(posedge aclk);
    #1;
    checks++;
    if (beat_seen !== 1'b0 || frame_count !== 10'd0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_stale: got seen=%0b fc=%0d rdy=%0b, required seen=0 fc=0 rdy=1",
               beat_seen, frame_count, s_tready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_frame();
    test_oversize_drop();
    test_stall_toggle();
    test_commit_collide();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_ethernet_tx_fifo.md
AXI_ETHERNET_TX_FIFO -- requirements
Module: axi_ethernet_tx_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- C_TDATA_WIDTH, 32, stream data width in bits.
- C_DEPTH_LOG2, 9, log2 of the buffer depth in words (512 words).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- aclk  in  1  sole clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  C_TDATA_WIDTH  host frame data.
- s_axis_tkeep  in  C_TDATA_WIDTH/8  byte enables.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted.
- m_axis_tdata  out  C_TDATA_WIDTH  data to the bridge txd slave port.
- m_axis_tkeep  out  C_TDATA_WIDTH/8  byte enables.
- m_axis_tlast  out  1  last beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  bridge ready.
- frame_count  out  C_DEPTH_LOG2+1  committed frames not yet fully read.
- drop_count  out  16  dropped frames, saturating.

Function
REQ-003 The block SHALL be a store-and-forward frame FIFO: no beat of a frame appears on m_axis until that frame's tlast beat has been written.
REQ-004 Storage width SHALL be C_TDATA_WIDTH + C_TDATA_WIDTH/8 + 1 (data, keep, last); tkeep and tlast SHALL pass through unmodified.
REQ-005 Pointers (wr_ptr, commit_ptr, rd_ptr) SHALL be C_DEPTH_LOG2+1 bits and wrap modulo 2^(C_DEPTH_LOG2+1).
- Free space SHALL be 2^C_DEPTH_LOG2 - (wr_ptr - rd_ptr).
REQ-006 The write FSM SHALL have two states.
- WR_ACCEPT: a beat is written when valid&ready; wr_ptr increments.
  - On a tlast write, commit_ptr SHALL become wr_ptr+1 and frame_count SHALL increment.
  - If valid and free space = 0, the beat SHALL NOT be stored, wr_ptr SHALL rewind to commit_ptr, and the state SHALL go to WR_DROP (or stay in WR_ACCEPT if that beat has tlast).
- WR_DROP: beats SHALL be accepted and discarded; on the tlast beat, drop_count SHALL increment (saturating at 0xFFFF) and the state SHALL return to WR_ACCEPT.
REQ-007 A drop caused by a beat carrying tlast SHALL also increment drop_count.
REQ-008 s_axis_tready SHALL be 1 in both write states whenever not in reset; the block never backpressures the host.
REQ-009 A frame of exactly 2^C_DEPTH_LOG2 words written into an empty FIFO SHALL be accepted; any larger frame SHALL always be dropped.
REQ-010 The read side SHALL use a 1-cycle synchronous RAM read plus a two-entry output stage (registered output plus prefetch).
- m_axis_* SHALL be driven from registers.
- Read SHALL proceed only while rd_ptr != commit_ptr.
REQ-011 Latency: with the FIFO empty, m_axis_tvalid SHALL rise exactly 3 cycles after the cycle accepting a frame's tlast beat.
REQ-012 Throughput: with m_axis_tready held high, committed beats SHALL leave at 1 beat/cycle with no bubbles, including across frame boundaries.
REQ-013 m_axis_tvalid SHALL NOT deassert, and m_axis_tdata/tkeep/tlast SHALL NOT change, while tvalid=1 and tready=0.
REQ-014 frame_count SHALL decrement on the m_axis tlast handshake.
- A commit and an output tlast handshake in the same cycle SHALL leave frame_count unchanged.
REQ-015 Empty output (frame_count=0, output stage empty) SHALL hold m_axis_tvalid=0 with no other side effect.

Reset
REQ-016 aresetn low SHALL asynchronously force:
- write FSM to WR_ACCEPT;
- all pointers, frame_count and drop_count to 0;
- m_axis_tvalid, m_axis_tlast and s_axis_tready to 0;
- m_axis_tdata and m_axis_tkeep to 0.
REQ-017 A frame partially written or partially read when reset asserts SHALL be discarded; RAM contents need not be cleared.
REQ-018 s_axis_tready SHALL rise on the first aclk edge after aresetn deasserts.

Structure
REQ-019 Package axi_eth_pkg SHALL hold the write-state encodings (WR_ACCEPT=0, WR_DROP=1), the default data width and depth, and the drop_count width.
REQ-020 Storage SHALL be one sub-module, axi_ethernet_tx_fifo_ram: a simple dual-port RAM with one write port, one synchronous read port, and no reset.

Verification
REQ-021 The bench SHALL cover these directed scenarios.
- One 1-word frame (tdata=0xDEADBEEF, tkeep=0xF, tlast=1) into empty FIFO, m_tready=1 -> m_tvalid rises 3 cycles later with identical data/keep/last; frame_count goes 0->1->0.
- Three back-to-back 4-word frames, m_tready=1 -> 12 beats in order with no gap once streaming; tlast on beats 4, 8 and 12.
- 513-word frame with C_DEPTH_LOG2=9 -> s_tready stays 1, drop_count=1, frame_count=0, no m_tvalid; a following 2-word frame passes intact.
- m_tready toggled 1/0 every cycle during a 16-word frame -> all 16 beats delivered once; outputs stable while stalled.
- aresetn pulsed low mid-read of a 10-word frame -> tvalid=0 immediately, counters 0, no stale beat after reset.
- Commit of frame N on the same cycle as output tlast of frame N-1 -> frame_count unchanged that cycle.
